// File: rtl/gated_counter_ctrl_pkg.sv
// Shared types and default widths for the gated counter sequencing controller.
package gated_counter_ctrl_pkg;

    localparam int unsigned DefCntW  = 4;
    localparam int unsigned DefGapW  = 8;
    localparam int unsigned DefStatW = 16;

    typedef enum logic [1:0] {
        StIdle,
        StWake,
        StRun,
        StGap
    } state_e;

endpackage

// File: rtl/gated_counter_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module gated_counter_ctrl_sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] count_o
);

    logic [W-1:0] count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (clr_i) begin
            count_q <= '0;
        end else if (inc_i && (count_q != '1)) begin
            count_q <= count_q + W'(1);
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/gated_counter_ctrl.sv
// Drives the counter's ICG enable so it sees exactly burst_len edges per burst,
// one-shot or periodic, and tracks gated-off cycles while busy.
module gated_counter_ctrl
    import gated_counter_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W  = DefCntW,
    parameter int unsigned GAP_W  = DefGapW,
    parameter int unsigned STAT_W = DefStatW
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stop,
    input  logic              mode,
    input  logic [CNT_W-1:0]  burst_len,
    input  logic [GAP_W-1:0]  gap_len,
    output logic              gate_en,
    output logic              busy,
    output logic              done,
    output logic [STAT_W-1:0] gated_cycles
);

    state_e             state_q;
    logic               mode_q;
    logic [CNT_W-1:0]   len_q;
    logic [CNT_W-1:0]   remaining_q;
    logic [GAP_W-1:0]   gap_q;
    logic [GAP_W-1:0]   gap_cnt_q;
    logic               gate_en_q;
    logic               busy_q;
    logic               done_q;
    logic               start_acc;
    logic               stat_inc;

    assign start_acc = (state_q == StIdle) && start && !stop && (burst_len != '0);
    assign stat_inc  = (state_q == StWake) || (state_q == StGap);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            mode_q      <= 1'b0;
            len_q       <= '0;
            remaining_q <= '0;
            gap_q       <= '0;
            gap_cnt_q   <= '0;
            gate_en_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            // stop wins over everything, including a burst finishing this cycle
            if (stop) begin
                state_q   <= StIdle;
                gate_en_q <= 1'b0;
                busy_q    <= 1'b0;
            end else begin
                case (state_q)
                    StIdle: begin
                        if (start_acc) begin
                            mode_q  <= mode;
                            len_q   <= burst_len;
                            gap_q   <= gap_len;
                            busy_q  <= 1'b1;
                            state_q <= StWake;
                        end
                    end
                    StWake: begin
                        remaining_q <= len_q;
                        gate_en_q   <= 1'b1;
                        state_q     <= StRun;
                    end
                    StRun: begin
                        if (remaining_q == CNT_W'(1)) begin
                            gate_en_q <= 1'b0;
                            done_q    <= 1'b1;
                            if (!mode_q) begin
                                busy_q  <= 1'b0;
                                state_q <= StIdle;
                            end else if (gap_q != '0) begin
                                gap_cnt_q <= gap_q;
                                state_q   <= StGap;
                            end else begin
                                state_q <= StWake;
                            end
                        end else begin
                            remaining_q <= remaining_q - CNT_W'(1);
                        end
                    end
                    StGap: begin
                        if (gap_cnt_q == GAP_W'(1)) begin
                            state_q <= StWake;
                        end else begin
                            gap_cnt_q <= gap_cnt_q - GAP_W'(1);
                        end
                    end
                    default: begin
                        state_q   <= StIdle;
                        gate_en_q <= 1'b0;
                        busy_q    <= 1'b0;
                    end
                endcase
            end
        end
    end

    gated_counter_ctrl_sat_counter #(
        .W (STAT_W)
    ) u_stat (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_i   (start_acc),
        .inc_i   (stat_inc),
        .count_o (gated_cycles)
    );

    assign gate_en = gate_en_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_gated_counter_ctrl.sv
// Randomized scoreboard bench: a timeline model predicts done pulses and end-of-run
// counter/statistic values; a negedge monitor consumes the predicted done events.
module tb_gated_counter_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       mode = 1'b0;
    logic [3:0] burst_len = '0;
    logic [7:0] gap_len = '0;

    logic        gate_en, busy, done;
    logic [15:0] gated_cycles;
    logic        gate_en2, busy2, done2;
    logic [1:0]  gated2;

    int         checks = 0;
    int         failures = 0;
    int         cyc = 0;
    logic [3:0] cnt = '0;

    typedef struct {
        int cyc;
        int cnt;
        int gated;
    } exp_t;
    exp_t exp_q[$];

    gated_counter_ctrl #(
        .CNT_W  (4),
        .GAP_W  (8),
        .STAT_W (16)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .stop         (stop),
        .mode         (mode),
        .burst_len    (burst_len),
        .gap_len      (gap_len),
        .gate_en      (gate_en),
        .busy         (busy),
        .done         (done),
        .gated_cycles (gated_cycles)
    );

    gated_counter_ctrl #(
        .CNT_W  (4),
        .GAP_W  (8),
        .STAT_W (2)
    ) dut_sat (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .stop         (stop),
        .mode         (mode),
        .burst_len    (burst_len),
        .gap_len      (gap_len),
        .gate_en      (gate_en2),
        .busy         (busy2),
        .done         (done2),
        .gated_cycles (gated2)
    );

    always #5 clk = ~clk;

    // Edge counter plus the gated 4-bit up-counter this block controls.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (gate_en) cnt <= cnt + 4'd1;
    end

    function automatic int sat3(input int v);
        return (v > 3) ? 3 : v;
    endfunction

    task automatic check(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Monitor: every done pulse must match the oldest predicted event.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && (done || done2)) begin
            check("done_both_widths", int'(done2), int'(done));
            if (exp_q.size() == 0) begin
                check("unexpected_done", int'(done), 0);
            end else begin
                e = exp_q.pop_front();
                check("done_cycle", cyc, e.cyc);
                check("done_counter", int'(cnt), e.cnt);
                check("done_gated", int'(gated_cycles), e.gated);
                check("done_gated_sat", int'(gated2), sat3(e.gated));
            end
        end
    end

    // One run: s = stop offset from the accept edge (0 = none, one-shot only).
    task automatic run_one(input bit periodic, input int len, input int gap, input int s,
                           input bit interfere);
        int k, p, j, end_edge, e, r, ph, exp_cnt, exp_gated;
        @(posedge clk);
        #1;
        k = cyc + 1;
        mode = periodic;
        burst_len = len[3:0];
        gap_len = gap[7:0];
        start = 1'b1;
        stop = 1'b0;
        p = periodic ? (len + 1 + gap) : (len + 1);
        j = (s > 0) ? (k + s) : 0;
        end_edge = (s > 0) ? j : (k + len + 1);
        for (int b = 0; b < 1000; b++) begin
            e = k + b * p + len + 1;
            if (s > 0 && e >= j) break;
            exp_q.push_back('{cyc: e, cnt: (int'(cnt) + (b + 1) * len) % 16,
                              gated: b * (gap + 1) + 1});
            if (!periodic) break;
        end
        // Cycle before edge t: phase 0 = WAKE, 1..len = RUN, beyond = GAP.
        exp_cnt = int'(cnt);
        exp_gated = 0;
        for (int t = k + 1; t <= end_edge; t++) begin
            r = t - 1 - k;
            ph = r % p;
            if (ph >= 1 && ph <= len) exp_cnt++;
            else exp_gated++;
        end
        for (int c = k; c <= end_edge; c++) begin
            @(posedge clk);
            #1;
            start = interfere && (c + 1 <= end_edge) && ($urandom_range(0, 2) == 0);
            burst_len = 4'($urandom);
            gap_len = 8'($urandom);
            mode = 1'($urandom);
            stop = (c + 1 == j);
        end
        start = 1'b0;
        stop = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("end_busy", int'(busy), 0);
        check("end_gate_en", int'(gate_en), 0);
        check("end_done", int'(done), 0);
        check("end_counter", int'(cnt), exp_cnt % 16);
        check("end_gated", int'(gated_cycles), exp_gated);
        check("end_gated_sat", int'(gated2), sat3(exp_gated));
        check("end_busy_sat", int'(busy2), 0);
        check("pending_done", exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic idle_probe(input bit with_stop, input int len);
        @(posedge clk);
        #1;
        start = 1'b1;
        stop = with_stop;
        mode = 1'b0;
        burst_len = len[3:0];
        @(posedge clk);
        #1;
        start = 1'b0;
        stop = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check(with_stop ? "startstop_busy" : "len0_busy", int'(busy), 0);
        check(with_stop ? "startstop_gate" : "len0_gate", int'(gate_en), 0);
    endtask

    initial begin
        int periodic, len, gap, s, p;
        logic [3:0] c_hold;
        #3;
        check("reset_gate_en", int'(gate_en), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        check("reset_gated", int'(gated_cycles), 0);
        @(negedge clk);
        rst_n = 1'b1;

        run_one(1'b0, 5, 0, 0, 1'b0);
        run_one(1'b1, 3, 2, 19, 1'b0);
        run_one(1'b0, 15, 0, 0, 1'b0);
        run_one(1'b0, 4, 0, 5, 1'b0);
        run_one(1'b0, 6, 3, 0, 1'b1);
        idle_probe(1'b0, 0);
        idle_probe(1'b1, 7);
        run_one(1'b1, 1, 0, 20, 1'b0);

        for (int i = 0; i < 40; i++) begin
            periodic = int'($urandom_range(0, 1));
            len = int'($urandom_range(1, 15));
            gap = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 40))
                                              : int'($urandom_range(0, 3));
            p = len + 1 + gap;
            if (periodic != 0) s = int'($urandom_range(1, 3 * p + 3));
            else s = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, len + 1));
            run_one(periodic[0], len, gap, s, 1'($urandom));
        end

        // Asynchronous reset in the middle of a run.
        @(posedge clk);
        #1;
        start = 1'b1;
        mode = 1'b0;
        burst_len = 4'd5;
        gap_len = '0;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        check("prereset_gate_en", int'(gate_en), 1);
        check("prereset_gated", int'(gated_cycles), 1);
        rst_n = 1'b0;
        #1;
        check("midreset_gate_en", int'(gate_en), 0);
        check("midreset_busy", int'(busy), 0);
        check("midreset_done", int'(done), 0);
        check("midreset_gated", int'(gated_cycles), 0);
        check("midreset_gate_en_sat", int'(gate_en2), 0);
        c_hold = cnt;
        @(posedge clk);
        #1;
        check("midreset_cnt_hold", int'(cnt), int'(c_hold));
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("postreset_busy", int'(busy), 0);
        check("postreset_cnt_hold", int'(cnt), int'(c_hold));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
